// File: rtl/adiciona_chave_rodada_pkg.sv
// Shared AES definitions for the round pipeline: widths, GF(2^8) constants,
// FSM encoding, the S-box table and the xtime helper.
package adiciona_chave_rodada_pkg;

   localparam int BLOCO_W   = 128;
   localparam int PALAVRA_W = 32;

   localparam logic [7:0] RCON_INICIAL = 8'h01;
   localparam logic [7:0] POLI_AES     = 8'h1b;

   typedef enum logic [0:0] {
      SEM_CHAVE = 1'b0,
      ATIVO     = 1'b1
   } estado_t;

   // Entry 0x00 occupies the top byte so the table reads like the usual 16x16 grid.
   localparam logic [2047:0] SBOX_TAB = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? POLI_AES : 8'h00);
   endfunction

endpackage

// File: rtl/adiciona_chave_rodada_sbox.sv
// Combinational AES S-box lookup, one byte in and one byte out.
module adiciona_chave_rodada_sbox
   import adiciona_chave_rodada_pkg::*;
(
   input  logic [7:0] entrada,
   output logic [7:0] saida
);

   logic [10:0] pos_s;

   // Inverting the index maps byte value 0 onto the most significant table slot.
   assign pos_s = {~entrada, 3'b000};
   assign saida = SBOX_TAB[pos_s +: 8];

endmodule

// File: rtl/adiciona_chave_rodada.sv
// AES-128 AddRoundKey with on-the-fly key expansion: one round key per
// accepted block, cycling through keys 0..NUM_RODADAS of the loaded cipher key.
module adiciona_chave_rodada
   import adiciona_chave_rodada_pkg::*;
#(
   parameter int NUM_RODADAS = 10
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic               chave_carga,
   input  logic [BLOCO_W-1:0] chave,
   input  logic               entrada_valida,
   output logic               entrada_pronta,
   input  logic [BLOCO_W-1:0] bloco,
   output logic               saida_valida,
   input  logic               saida_pronta,
   output logic [BLOCO_W-1:0] saida,
   output logic [3:0]         rodada_saida,
   output logic               ultima
);

   estado_t              estado_r;
   estado_t              estado_prox_s;
   logic [BLOCO_W-1:0]   chave_base_r;
   logic [BLOCO_W-1:0]   chave_atual_r;
   logic [3:0]           contador_r;
   logic [7:0]           rcon_r;
   logic                 saida_valida_r;
   logic [BLOCO_W-1:0]   saida_r;
   logic [3:0]           rodada_saida_r;
   logic                 ultima_r;

   logic                 transf_s;
   logic                 ultima_chave_s;
   logic [PALAVRA_W-1:0] w0_s, w1_s, w2_s, w3_s;
   logic [PALAVRA_W-1:0] rot_s, sub_s;
   logic [PALAVRA_W-1:0] n0_s, n1_s, n2_s, n3_s;
   logic [BLOCO_W-1:0]   proxima_s;

   assign entrada_pronta = (estado_r == ATIVO) && !chave_carga && (!saida_valida_r || saida_pronta);
   assign transf_s       = entrada_valida && entrada_pronta;
   assign ultima_chave_s = (contador_r == 4'(NUM_RODADAS));

   assign w0_s  = chave_atual_r[127:96];
   assign w1_s  = chave_atual_r[95:64];
   assign w2_s  = chave_atual_r[63:32];
   assign w3_s  = chave_atual_r[31:0];
   assign rot_s = {w3_s[23:0], w3_s[31:24]};

   for (genvar i = 0; i < 4; i++) begin : g_subword
      adiciona_chave_rodada_sbox u_sbox (
         .entrada (rot_s[8*i +: 8]),
         .saida   (sub_s[8*i +: 8])
      );
   end

   assign n0_s      = w0_s ^ sub_s ^ {rcon_r, 24'h000000};
   assign n1_s      = w1_s ^ n0_s;
   assign n2_s      = w2_s ^ n1_s;
   assign n3_s      = w3_s ^ n2_s;
   assign proxima_s = {n0_s, n1_s, n2_s, n3_s};

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estado_r <= SEM_CHAVE;
      end else begin
         estado_r <= estado_prox_s;
      end
   end

   // FSM next state: once a key is loaded the stage stays active until reset
   always_comb begin
      estado_prox_s = estado_r;
      case (estado_r)
         SEM_CHAVE: begin
            if (chave_carga) begin
               estado_prox_s = ATIVO;
            end else begin
               estado_prox_s = SEM_CHAVE;
            end
         end
         ATIVO:   estado_prox_s = ATIVO;
         default: estado_prox_s = SEM_CHAVE;
      endcase
   end

   // Key schedule state: advances only when a block is actually accepted
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chave_base_r  <= {BLOCO_W{1'b0}};
         chave_atual_r <= {BLOCO_W{1'b0}};
         contador_r    <= 4'd0;
         rcon_r        <= RCON_INICIAL;
      end else if (chave_carga) begin
         chave_base_r  <= chave;
         chave_atual_r <= chave;
         contador_r    <= 4'd0;
         rcon_r        <= RCON_INICIAL;
      end else if (transf_s) begin
         if (ultima_chave_s) begin
            chave_atual_r <= chave_base_r;
            contador_r    <= 4'd0;
            rcon_r        <= RCON_INICIAL;
         end else begin
            chave_atual_r <= proxima_s;
            contador_r    <= contador_r + 4'd1;
            rcon_r        <= xtime(rcon_r);
         end
      end
   end

   // One-entry output register with valid/ready handshake
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         saida_valida_r <= 1'b0;
         saida_r        <= {BLOCO_W{1'b0}};
         rodada_saida_r <= 4'd0;
         ultima_r       <= 1'b0;
      end else if (transf_s) begin
         saida_valida_r <= 1'b1;
         saida_r        <= bloco ^ chave_atual_r;
         rodada_saida_r <= contador_r;
         ultima_r       <= ultima_chave_s;
      end else if (saida_pronta) begin
         saida_valida_r <= 1'b0;
      end
   end

   assign saida_valida = saida_valida_r;
   assign saida        = saida_r;
   assign rodada_saida = rodada_saida_r;
   assign ultima       = ultima_r;

endmodule

// File: tb/tb_adiciona_chave_rodada.sv
// Self-checking bench: behavioural AES key-schedule model (FIPS-197 word
// expansion, S-box from GF(2^8) inversion) against the DUT, plus known vectors.
module tb_adiciona_chave_rodada;

   logic         clk = 1'b0;
   logic         rst;
   logic         chave_carga;
   logic [127:0] chave;
   logic         entrada_valida;
   logic         entrada_pronta;
   logic [127:0] bloco;
   logic         saida_valida;
   logic         saida_pronta;
   logic [127:0] saida;
   logic [3:0]   rodada_saida;
   logic         ultima;

   int checks   = 0;
   int failures = 0;

   logic [7:0]   sbox_m [256];
   logic [127:0] rk_m   [11];
   bit           m_carregada;
   int           m_rod;
   bit           m_val;
   logic [127:0] m_saida;
   logic [3:0]   m_rodsaida;
   bit           m_ult;

   localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   adiciona_chave_rodada #(.NUM_RODADAS(10)) dut (
      .clk            (clk),
      .rst            (rst),
      .chave_carga    (chave_carga),
      .chave          (chave),
      .entrada_valida (entrada_valida),
      .entrada_pronta (entrada_pronta),
      .bloco          (bloco),
      .saida_valida   (saida_valida),
      .saida_pronta   (saida_pronta),
      .saida          (saida),
      .rodada_saida   (rodada_saida),
      .ultima         (ultima)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] a;
      p = 8'h00;
      a = a_in;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ a;
         a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] d;
      d = {b, b} << n;
      return d[15:8];
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   task automatic expand(input logic [127:0] k);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc [11];
      rc[1] = 8'h01;
      for (int j = 2; j < 11; j++) rc[j] = gmul(rc[j-1], 8'h02);
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
            t = t ^ {rc[i/4], 24'h000000};
         end
         w[i] = w[i-4] ^ t;
      end
      for (int j = 0; j < 11; j++) rk_m[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
   endtask

   task automatic chk(input string nome, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", nome, got, exp);
      end
   endtask

   task automatic compara_saidas();
      chk("saida_valida", 128'(saida_valida), 128'(m_val));
      chk("saida", saida, m_saida);
      chk("rodada_saida", 128'(rodada_saida), 128'(m_rodsaida));
      chk("ultima", 128'(ultima), 128'(m_ult));
   endtask

   // Drive one cycle from a negedge, check readiness, advance model, check outputs.
   task automatic ciclo(input bit carga, input logic [127:0] k, input bit ev,
                        input logic [127:0] b, input bit sp);
      bit exp_pronta;
      chave_carga    = carga;
      chave          = k;
      entrada_valida = ev;
      bloco          = b;
      saida_pronta   = sp;
      #1;
      exp_pronta = m_carregada && !carga && (!m_val || sp);
      chk("entrada_pronta", 128'(entrada_pronta), 128'(exp_pronta));
      if (ev && exp_pronta) begin
         m_saida    = b ^ rk_m[m_rod];
         m_rodsaida = 4'(m_rod);
         m_ult      = (m_rod == 10);
         m_val      = 1'b1;
         m_rod      = (m_rod == 10) ? 0 : m_rod + 1;
      end else if (sp) begin
         m_val = 1'b0;
      end
      if (carga) begin
         expand(k);
         m_rod       = 0;
         m_carregada = 1'b1;
      end
      @(negedge clk);
      compara_saidas();
   endtask

   task automatic aplica_reset();
      rst = 1'b1;
      #1;
      m_carregada = 1'b0;
      m_rod       = 0;
      m_val       = 1'b0;
      m_saida     = 128'h0;
      m_rodsaida  = 4'd0;
      m_ult       = 1'b0;
      compara_saidas();
      chk("pronta_em_reset", 128'(entrada_pronta), 128'(1'b0));
      @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      rst            = 1'b1;
      chave_carga    = 1'b0;
      chave          = 128'h0;
      entrada_valida = 1'b0;
      bloco          = 128'h0;
      saida_pronta   = 1'b0;
      build_sbox();
      for (int j = 0; j < 11; j++) rk_m[j] = 128'h0;
      @(negedge clk);
      aplica_reset();

      // Known-answer anchors for the model itself
      expand(K_FIPS);
      chk("modelo_rk1", rk_m[1], 128'ha0fafe1788542cb123a339392a6c7605);
      chk("modelo_rk10", rk_m[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      for (int i = 0; i < 3; i++) ciclo(1'b0, 128'h0, 1'b1, rnd128(), 1'b1);
      ciclo(1'b1, K_FIPS, 1'b1, rnd128(), 1'b1);
      ciclo(1'b1, K_FIPS, 1'b1, rnd128(), 1'b1);
      chk("carga_bloqueia_transf", 128'(saida_valida), 128'(1'b0));

      for (int r = 0; r < 11; r++) begin
         ciclo(1'b0, 128'h0, 1'b1, 128'h0, 1'b1);
         if (r == 0) begin
            chk("kat_r0", saida, K_FIPS);
            chk("kat_r0_rod", 128'(rodada_saida), 128'd0);
         end
         if (r == 1) begin
            chk("kat_r1", saida, 128'ha0fafe1788542cb123a339392a6c7605);
            chk("kat_r1_rod", 128'(rodada_saida), 128'd1);
         end
      end
      chk("kat_r10", saida, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      chk("kat_r10_rod", 128'(rodada_saida), 128'd10);
      chk("kat_r10_ult", 128'(ultima), 128'd1);
      ciclo(1'b0, 128'h0, 1'b1, {128{1'b1}}, 1'b1);
      chk("kat_wrap", saida, 128'hd481eae9d7512d595408ea77f630b0c3);
      chk("kat_wrap_rod", 128'(rodada_saida), 128'd0);
      chk("kat_wrap_ult", 128'(ultima), 128'd0);

      // Backpressure: second block must still see round key 1
      ciclo(1'b1, K_FIPS, 1'b0, 128'h0, 1'b1);
      ciclo(1'b0, 128'h0, 1'b1, 128'h0123456789abcdef0123456789abcdef, 1'b0);
      for (int i = 0; i < 3; i++) begin
         ciclo(1'b0, 128'h0, 1'b1, 128'h0, 1'b0);
         chk("estavel", saida, 128'h0123456789abcdef0123456789abcdef ^ K_FIPS);
      end
      ciclo(1'b0, 128'h0, 1'b1, 128'h0, 1'b1);
      chk("bp_r1", saida, 128'ha0fafe1788542cb123a339392a6c7605);
      chk("bp_r1_rod", 128'(rodada_saida), 128'd1);

      // Randomised traffic with occasional key reloads
      for (int i = 0; i < 3000; i++) begin
         ciclo(($urandom_range(0, 63) == 0), rnd128(), bit'($urandom_range(0, 3) != 0),
               rnd128(), bit'($urandom_range(0, 2) != 0));
      end

      // Reset mid-operation, then reload
      ciclo(1'b1, K_FIPS, 1'b0, 128'h0, 1'b1);
      for (int i = 0; i < 5; i++) ciclo(1'b0, 128'h0, 1'b1, rnd128(), 1'b1);
      aplica_reset();
      ciclo(1'b0, 128'h0, 1'b1, 128'h0, 1'b1);
      ciclo(1'b1, K_FIPS, 1'b0, 128'h0, 1'b1);
      ciclo(1'b0, 128'h0, 1'b1, 128'h0, 1'b1);
      chk("pos_reset_r0", saida, K_FIPS);
      chk("pos_reset_rod", 128'(rodada_saida), 128'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
